// File: rtl/lcd_nibble_monitor.sv
// lcd_nibble_monitor
// Passive receiver for the HD44780 4-bit write interface. It samples the LCD
// pins, follows the 3,3,3,2 power-up sync, pairs nibbles into bytes and tracks
// the DDRAM address.
// Optional feature: define LCD_SHADOW_EN to keep a 16-character line shadow
// readable through RdIdx/RdChar. Without it, RdChar is constant 0x00.
module lcd_nibble_monitor (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [11:8] LCD_Data,
  input  logic        LCD_E,
  input  logic        LCD_RS,
  input  logic        LCD_RW,
  input  logic [3:0]  RdIdx,
  output logic [7:0]  ByteValue,
  output logic        ByteIsData,
  output logic        ByteValid,
  output logic        Synced,
  output logic [6:0]  Addr,
  output logic        ClearSeen,
  output logic        ProtoErr,
  output logic [7:0]  RdChar
);

  typedef enum logic [1:0] {S_BOOT, S_WANT2, S_HIGH, S_LOW} state_t;

  // two-flop input stage plus registered falling-edge event
  logic       r_s1_e, r_s1_rs, r_s1_rw;
  logic [3:0] r_s1_d;
  logic       r_s2_e, r_s2_rs, r_s2_rw;
  logic [3:0] r_s2_d;
  logic       r_edge, r_rs;
  logic [3:0] r_nib;

  // decoder state and registered outputs
  state_t     r_state, w_state_next;
  logic [1:0] r_cnt, w_cnt_next;
  logic [3:0] r_hi_nib, w_hi_nib_next;
  logic       r_hi_rs, w_hi_rs_next;
  logic [7:0] r_byte, w_byte_next;
  logic       r_is_data, w_is_data_next;
  logic       r_valid, w_valid_next;
  logic       r_synced, w_synced_next;
  logic [6:0] r_addr, w_addr_next;
  logic       r_clear, w_clear_next;
  logic       r_perr, w_perr_next;
  logic       w_shadow_we, w_shadow_clr;
  logic [7:0] w_byte;

  assign w_byte = {r_hi_nib, r_nib};

  // synchronise pins; an edge is E high in stage 2 and low in stage 1, and
  // edges belonging to read cycles are dropped right here
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_s1_e  <= 1'b0; r_s1_rs <= 1'b0; r_s1_rw <= 1'b0; r_s1_d <= 4'h0;
      r_s2_e  <= 1'b0; r_s2_rs <= 1'b0; r_s2_rw <= 1'b0; r_s2_d <= 4'h0;
      r_edge  <= 1'b0; r_rs    <= 1'b0; r_nib   <= 4'h0;
    end else begin
      r_s1_e  <= LCD_E;  r_s1_rs <= LCD_RS; r_s1_rw <= LCD_RW; r_s1_d <= LCD_Data;
      r_s2_e  <= r_s1_e; r_s2_rs <= r_s1_rs; r_s2_rw <= r_s1_rw; r_s2_d <= r_s1_d;
      r_edge  <= r_s2_e & ~r_s1_e & ~r_s2_rw;
      r_rs    <= r_s2_rs;
      r_nib   <= r_s2_d;
    end
  end

  // state and output registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= S_BOOT;
      r_cnt     <= 2'd0;
      r_hi_nib  <= 4'h0;
      r_hi_rs   <= 1'b0;
      r_byte    <= 8'h00;
      r_is_data <= 1'b0;
      r_valid   <= 1'b0;
      r_synced  <= 1'b0;
      r_addr    <= 7'h00;
      r_clear   <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_hi_nib  <= w_hi_nib_next;
      r_hi_rs   <= w_hi_rs_next;
      r_byte    <= w_byte_next;
      r_is_data <= w_is_data_next;
      r_valid   <= w_valid_next;
      r_synced  <= w_synced_next;
      r_addr    <= w_addr_next;
      r_clear   <= w_clear_next;
      r_perr    <= w_perr_next;
    end
  end

  // next-state: boot sync, nibble pairing and command/data decode
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_hi_nib_next  = r_hi_nib;
    w_hi_rs_next   = r_hi_rs;
    w_byte_next    = r_byte;
    w_is_data_next = r_is_data;
    w_valid_next   = 1'b0;
    w_synced_next  = r_synced;
    w_addr_next    = r_addr;
    w_clear_next   = 1'b0;
    w_perr_next    = 1'b0;
    w_shadow_we    = 1'b0;
    w_shadow_clr   = 1'b0;
    if (r_edge) begin
      case (r_state)
        S_BOOT: begin
          if (r_nib == 4'h3) begin
            if (r_cnt == 2'd2) begin
              w_state_next = S_WANT2;
              w_cnt_next   = 2'd0;
            end else begin
              w_cnt_next = r_cnt + 2'd1;
            end
          end else begin
            w_cnt_next = 2'd0;
          end
        end
        S_WANT2: begin
          if (r_nib == 4'h2) begin
            w_synced_next = 1'b1;
            w_state_next  = S_HIGH;
          end else if (r_nib != 4'h3) begin
            w_state_next = S_BOOT;
            w_cnt_next   = 2'd0;
          end
        end
        S_HIGH: begin
          w_hi_nib_next = r_nib;
          w_hi_rs_next  = r_rs;
          w_state_next  = S_LOW;
        end
        default: begin
          w_state_next = S_HIGH;
          if (r_rs == r_hi_rs) begin
            w_byte_next    = w_byte;
            w_is_data_next = r_rs;
            w_valid_next   = 1'b1;
            if (r_rs) begin
              // shadow write uses the pre-increment address
              w_shadow_we = (r_addr[6:4] == 3'd0);
              w_addr_next = r_addr + 7'd1;
            end else if (w_byte == 8'h01) begin
              w_addr_next  = 7'h00;
              w_clear_next = 1'b1;
              w_shadow_clr = 1'b1;
            end else if (w_byte[7]) begin
              w_addr_next = w_byte[6:0];
            end
          end else begin
            w_perr_next = 1'b1;
          end
        end
      endcase
    end
  end

  assign ByteValue  = r_byte;
  assign ByteIsData = r_is_data;
  assign ByteValid  = r_valid;
  assign Synced     = r_synced;
  assign Addr       = r_addr;
  assign ClearSeen  = r_clear;
  assign ProtoErr   = r_perr;

`ifdef LCD_SHADOW_EN
  logic [7:0] r_shadow [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_shadow
    // one shadow cell: blank on reset/clear, capture data written at its address
    always_ff @(posedge Clk) begin
      if (Rst || w_shadow_clr) begin
        r_shadow[gi] <= 8'h20;
      end else if (w_shadow_we && (r_addr[3:0] == 4'(gi))) begin
        r_shadow[gi] <= w_byte;
      end
    end
  end

  assign RdChar = r_shadow[RdIdx];
`else
  logic w_unused_ok;
  assign w_unused_ok = ^{RdIdx, w_shadow_we, w_shadow_clr};
  assign RdChar      = 8'h00;
`endif

endmodule

// File: tb/tb_lcd_nibble_monitor.sv
// Self-checking bench for lcd_nibble_monitor: directed scenarios plus random
// nibble traffic, checked every cycle against a behavioural model.
module tb_lcd_nibble_monitor;
  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [11:8] LCD_Data = 4'h0;
  logic        LCD_E = 1'b0, LCD_RS = 1'b0, LCD_RW = 1'b0;
  logic [3:0]  RdIdx = 4'h0;
  logic [7:0]  ByteValue, RdChar;
  logic        ByteIsData, ByteValid, Synced, ClearSeen, ProtoErr;
  logic [6:0]  Addr;

  lcd_nibble_monitor dut (
    .Clk(Clk), .Rst(Rst), .LCD_Data(LCD_Data), .LCD_E(LCD_E), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .RdIdx(RdIdx), .ByteValue(ByteValue), .ByteIsData(ByteIsData),
    .ByteValid(ByteValid), .Synced(Synced), .Addr(Addr), .ClearSeen(ClearSeen),
    .ProtoErr(ProtoErr), .RdChar(RdChar)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int nvalid = 0, nclear_valid = 0, nperr = 0;
  bit chk_en = 1'b0;
  bit rd_rand = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // f_* : state after all nibbles handed to the model so far
  // e_* : state the DUT outputs must show now (f_* delayed by pipeline latency)
  int         m_threes;
  bit         m_have_hi, m_hi_rs;
  logic [3:0] m_hi;
  logic [7:0] f_byte, e_byte;
  bit         f_isdata, e_isdata, f_synced, e_synced;
  logic [6:0] f_addr, e_addr;
  logic [7:0] f_sh [16];
  logic [7:0] e_sh [16];
  bit         p_act, p_v, p_c, p_e;
  int         p_cycle;

  task automatic model_reset();
    m_threes = 0; m_have_hi = 0; m_hi_rs = 0; m_hi = 0;
    f_byte = 0; e_byte = 0; f_isdata = 0; e_isdata = 0;
    f_synced = 0; e_synced = 0; f_addr = 0; e_addr = 0;
    for (int i = 0; i < 16; i++) begin f_sh[i] = 8'h20; e_sh[i] = 8'h20; end
    p_act = 0; p_v = 0; p_c = 0; p_e = 0; p_cycle = 0;
  endtask

  // called right after the cycle where E is driven low; effect visible 3 edges later
  task automatic model_nib(input logic [3:0] n, input bit rs, input bit rw);
    logic [7:0] b;
    if (rw) return;
    p_v = 0; p_c = 0; p_e = 0;
    if (!f_synced) begin
      if (n == 4'h3) m_threes++;
      else if (n == 4'h2 && m_threes >= 3) f_synced = 1;
      else m_threes = 0;
    end else if (!m_have_hi) begin
      m_have_hi = 1; m_hi = n; m_hi_rs = rs;
    end else begin
      m_have_hi = 0;
      b = {m_hi, n};
      if (rs != m_hi_rs) p_e = 1;
      else begin
        p_v = 1; f_byte = b; f_isdata = rs;
        if (rs) begin
          if (f_addr < 16) f_sh[f_addr[3:0]] = b;
          f_addr = f_addr + 7'd1;
        end else if (b == 8'h01) begin
          f_addr = 0; p_c = 1;
          for (int i = 0; i < 16; i++) f_sh[i] = 8'h20;
        end else if (b >= 8'h80) begin
          f_addr = b[6:0];
        end
      end
    end
    p_act = 1; p_cycle = cyc + 3;
  endtask

  // ---------------- compare process ----------------
  bit         x_v, x_c, x_e;
  logic [7:0] x_rd;
  always @(negedge Clk) begin
    x_v = 0; x_c = 0; x_e = 0;
    if (p_act && cyc == p_cycle) begin
      e_byte = f_byte; e_isdata = f_isdata; e_synced = f_synced; e_addr = f_addr;
      e_sh = f_sh;
      x_v = p_v; x_c = p_c; x_e = p_e; p_act = 0;
    end
`ifdef LCD_SHADOW_EN
    x_rd = e_sh[RdIdx];
`else
    x_rd = 8'h00;
`endif
    if (chk_en) begin
      chk("ByteValue", ByteValue, e_byte);
      chk("ByteIsData", ByteIsData, e_isdata);
      chk("ByteValid", ByteValid, x_v);
      chk("Synced", Synced, e_synced);
      chk("Addr", Addr, e_addr);
      chk("ClearSeen", ClearSeen, x_c);
      chk("ProtoErr", ProtoErr, x_e);
      chk("RdChar", RdChar, x_rd);
    end
    if (ByteValid === 1'b1) begin
      nvalid++;
      $display("byte 0x%02h data=%0d addr=0x%02h clear=%0d cycle %0d",
               ByteValue, ByteIsData, Addr, ClearSeen, cyc);
    end
    if (ByteValid === 1'b1 && ClearSeen === 1'b1) nclear_valid++;
    if (ProtoErr === 1'b1) nperr++;
  end

  initial forever begin
    @(posedge Clk); #2;
    if (rd_rand) RdIdx = 4'($urandom);
  end

  // ---------------- drivers ----------------
  task automatic send_nib(input logic [3:0] n, input bit rs, input bit rw);
    int hi = $urandom_range(2, 4);
    int lo = $urandom_range(3, 5);
    @(posedge Clk); #1;
    LCD_Data = n; LCD_RS = rs; LCD_RW = rw; LCD_E = 1'b1;
    repeat (hi) @(posedge Clk);
    #1 LCD_E = 1'b0;
    model_nib(n, rs, rw);
    @(posedge Clk); #1;
    LCD_Data = 4'($urandom); LCD_RS = 1'($urandom); LCD_RW = 1'($urandom);
    repeat (lo - 2) @(posedge Clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rs);
    send_nib(b[7:4], rs, 1'b0);
    send_nib(b[3:0], rs, 1'b0);
  endtask

  task automatic sync_seq();
    send_nib(4'h3, 1'b0, 1'b0);
    send_nib(4'h3, 1'b0, 1'b0);
    send_nib(4'h3, 1'b0, 1'b0);
    send_nib(4'h2, 1'b0, 1'b0);
  endtask

  task automatic settle();
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    chk_en = 0;
    @(posedge Clk); #1;
    Rst = 1'b1; LCD_E = 1'b0; LCD_RW = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    model_reset();
    chk_en = 1;
  endtask

  int  base;
  bit  cur_rs;
  logic [7:0] exp_rd;

  initial begin
    model_reset();
    do_reset();
    #1;
    chk("reset ByteValue", ByteValue, 8'h00);
    chk("reset ByteIsData", ByteIsData, 1'b0);
    chk("reset ByteValid", ByteValid, 1'b0);
    chk("reset Synced", Synced, 1'b0);
    chk("reset Addr", Addr, 7'h00);

    // broken boot then full boot
    send_nib(4'h3, 0, 0); send_nib(4'h3, 0, 0); send_nib(4'h5, 0, 0);
    settle();
    chk("boot abort Synced", Synced, 1'b0);
    sync_seq();
    settle();
    chk("boot Synced", Synced, 1'b1);
    chk("boot no bytes", nvalid, 0);

    send_byte(8'h85, 1'b0);
    settle();
    chk("cmd85 value", ByteValue, 8'h85);
    chk("cmd85 isdata", ByteIsData, 1'b0);
    chk("cmd85 addr", Addr, 7'h05);

    send_byte(8'h01, 1'b0);
    settle();
    chk("clear addr", Addr, 7'h00);
    chk("clear with valid", nclear_valid, 1);

    send_byte(8'h48, 1'b1);
    send_byte(8'h69, 1'b1);
    settle();
    chk("hi addr", Addr, 7'h02);
    rd_rand = 0;
    for (int i = 0; i < 3; i++) begin
      RdIdx = 4'(i);
      #1;
`ifdef LCD_SHADOW_EN
      exp_rd = (i == 0) ? 8'h48 : (i == 1) ? 8'h69 : 8'h20;
`else
      exp_rd = 8'h00;
`endif
      chk("shadow literal", RdChar, exp_rd);
    end
    rd_rand = 1;

    // RS mismatch between nibbles
    send_nib(4'h4, 1'b1, 1'b0);
    send_nib(4'h1, 1'b0, 1'b0);
    settle();
    chk("perr count", nperr, 1);
    chk("perr no byte", nvalid, 4);
    send_byte(8'h41, 1'b1);
    settle();
    chk("after perr value", ByteValue, 8'h41);
    chk("after perr addr", Addr, 7'h03);

    // read cycles ignored; address wrap
    send_nib(4'h9, 1'b0, 1'b1);
    send_byte(8'hFF, 1'b0);
    settle();
    chk("addr 7F", Addr, 7'h7F);
    send_nib(4'h7, 1'b1, 1'b1);
    send_byte(8'h5A, 1'b1);
    settle();
    chk("addr wrap", Addr, 7'h00);
    chk("wrap value", ByteValue, 8'h5A);

    // random traffic
    cur_rs = 0;
    for (int k = 0; k < 300; k++) begin
      int r = $urandom_range(0, 99);
      if (r < 3) begin
        do_reset();
        send_nib(4'($urandom), 0, 0);
        send_nib(4'($urandom), 0, 0);
        sync_seq();
      end else begin
        if ($urandom_range(0, 9) == 0) cur_rs = ~cur_rs;
        send_nib(4'($urandom), cur_rs, (r < 10));
      end
    end
    settle();

    // reset mid-byte, then clear display after re-sync
    do_reset();
    sync_seq();
    send_nib(4'hA, 1'b0, 1'b0);
    do_reset();
    settle();
    chk("reset mid-byte Synced", Synced, 1'b0);
    sync_seq();
    base = nclear_valid;
    send_byte(8'h01, 1'b0);
    settle();
    chk("final clear pulse", nclear_valid, base + 1);
    chk("final addr", Addr, 7'h00);
    chk("final isdata", ByteIsData, 1'b0);

    repeat (4) @(posedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
